// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver. Samples the async rx line on ticks
// derived from the rx_clk oversample square wave. Each received byte is offered
// on a valid/ready holding register together with its frame and parity status.
module uart_rx_os #(
  parameter int DATA_BITS  = 8,
  parameter int OS_RATE    = 16,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_clk,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TICK_W = $clog2(OS_RATE);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);
  localparam logic [TICK_W-1:0] TICK_ZERO = {TICK_W{1'b0}};
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OS_RATE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OS_RATE - 1);
  localparam logic [BIT_W-1:0]  BIT_ZERO  = {BIT_W{1'b0}};
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    WAIT_HI = 3'd5
  } state_t;

  // Parity check result: 1 when data plus received parity bit violates the chosen sense.
  function automatic logic parity_bad_f(input logic [DATA_BITS-1:0] data, input logic pbit);
    parity_bad_f = (^data) ^ pbit ^ PARITY_ODD;
  endfunction

  logic                 rx_meta_r, rx_sync_r, rx_clk_d_r;
  logic                 rx_s, tick_s;
  state_t               state_r, state_s;
  logic [TICK_W-1:0]    tick_cnt_r, tick_cnt_s;
  logic [BIT_W-1:0]     bit_cnt_r, bit_cnt_s;
  logic [DATA_BITS-1:0] shift_r, shift_s;
  logic                 perr_r, perr_s;
  logic                 done_s, done_ferr_s;

  assign rx_s   = rx_sync_r;
  assign tick_s = rx_clk & ~rx_clk_d_r;

  // Two-flop synchroniser for rx (idle-high preset) and rx_clk edge history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_r  <= 1'b1;
      rx_sync_r  <= 1'b1;
      rx_clk_d_r <= 1'b0;
    end else begin
      rx_meta_r  <= rx;
      rx_sync_r  <= rx_meta_r;
      rx_clk_d_r <= rx_clk;
    end
  end

  // Receiver state, counters and shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      tick_cnt_r <= TICK_ZERO;
      bit_cnt_r  <= BIT_ZERO;
      shift_r    <= {DATA_BITS{1'b0}};
      perr_r     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_r    <= state_s;
      tick_cnt_r <= tick_cnt_s;
      bit_cnt_r  <= bit_cnt_s;
      shift_r    <= shift_s;
      perr_r     <= perr_s;
      busy       <= (state_s != IDLE);
    end
  end

  // Next-state logic: everything advances only on oversample ticks.
  always_comb begin
    state_s     = state_r;
    tick_cnt_s  = tick_cnt_r;
    bit_cnt_s   = bit_cnt_r;
    shift_s     = shift_r;
    perr_s      = perr_r;
    done_s      = 1'b0;
    done_ferr_s = 1'b0;
    if (tick_s) begin
      case (state_r)
        IDLE: begin
          if (!rx_s) begin
            state_s    = START;
            tick_cnt_s = TICK_ZERO;
          end else begin
            state_s = IDLE;
          end
        end
        START: begin
          if (tick_cnt_r == TICK_MID) begin
            tick_cnt_s = TICK_ZERO;
            bit_cnt_s  = BIT_ZERO;
            perr_s     = 1'b0;
            if (!rx_s) begin
              state_s = DATA;
            end else begin
              state_s = IDLE;
            end
          end else begin
            tick_cnt_s = tick_cnt_r + TICK_ONE;
          end
        end
        DATA: begin
          if (tick_cnt_r == TICK_LAST) begin
            tick_cnt_s = TICK_ZERO;
            shift_s    = {rx_s, shift_r[DATA_BITS-1:1]};
            bit_cnt_s  = bit_cnt_r + BIT_ONE;
            if (bit_cnt_r == BIT_LAST) begin
              state_s = PARITY_EN ? PARITY : STOP;
            end else begin
              state_s = DATA;
            end
          end else begin
            tick_cnt_s = tick_cnt_r + TICK_ONE;
          end
        end
        PARITY: begin
          if (tick_cnt_r == TICK_LAST) begin
            tick_cnt_s = TICK_ZERO;
            perr_s     = parity_bad_f(shift_r, rx_s);
            state_s    = STOP;
          end else begin
            tick_cnt_s = tick_cnt_r + TICK_ONE;
          end
        end
        STOP: begin
          if (tick_cnt_r == TICK_LAST) begin
            tick_cnt_s  = TICK_ZERO;
            done_s      = 1'b1;
            done_ferr_s = ~rx_s;
            state_s     = rx_s ? IDLE : WAIT_HI;
          end else begin
            tick_cnt_s = tick_cnt_r + TICK_ONE;
          end
        end
        WAIT_HI: begin
          if (rx_s) begin
            state_s = IDLE;
          end else begin
            state_s = WAIT_HI;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Holding register with valid/ready handshake; a full register drops new frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data    <= {DATA_BITS{1'b0}};
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else if (done_s) begin
      if (!rx_valid || rx_ready) begin
        rx_data    <= shift_r;
        rx_valid   <= 1'b1;
        frame_err  <= done_ferr_s;
        parity_err <= PARITY_EN ? perr_r : 1'b0;
        overrun    <= 1'b0;
      end else begin
        overrun <= 1'b1;
      end
    end else begin
      overrun <= 1'b0;
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: drives serial frames into a no-parity and an even-parity
// receiver and compares the presented bytes and flags with expected values.
`timescale 1ns/1ps
module tb_uart_rx_os;

  localparam int BIT_CLK = 256;  // rx_clk toggles every 8 clk -> 16 clk per tick -> 256 clk per bit
  localparam int NV      = 6;
  localparam int NR      = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_clk;
  logic       rx_clk_en = 1'b1;
  logic       rx = 1'b1, rx_p = 1'b1;
  logic       rx_ready = 1'b1, rdy_p = 1'b1;
  logic [7:0] rx_data, rx_data_p;
  logic       rx_valid, frame_err, parity_err, overrun, busy;
  logic       rx_valid_p, frame_err_p, parity_err_p, overrun_p, busy_p;

  uart_rx_os dut (
    .clk(clk), .rst(rst), .rx_clk(rx_clk), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun), .busy(busy)
  );

  uart_rx_os #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_p (
    .clk(clk), .rst(rst), .rx_clk(rx_clk), .rx(rx_p),
    .rx_data(rx_data_p), .rx_valid(rx_valid_p), .rx_ready(rdy_p),
    .frame_err(frame_err_p), .parity_err(parity_err_p), .overrun(overrun_p), .busy(busy_p)
  );

  initial forever #5 clk = ~clk;

  // Oversample clock: square wave, 8 clk high / 8 clk low, can be frozen.
  initial begin
    rx_clk = 1'b0;
    forever begin
      repeat (8) @(negedge clk);
      if (rx_clk_en) rx_clk = ~rx_clk;
    end
  end

  // Output monitors, sampled on the falling edge.
  int         valid_tot = 0, ovr_tot = 0, ovr_dbl = 0, busy_tot = 0;
  int         valid_p_tot = 0, ovr_p_tot = 0, busy_p_tot = 0;
  logic       ovr_prev = 1'b0;
  logic [7:0] last_data = 8'h00, last_data_p = 8'h00;
  logic       last_ferr = 1'b0, last_perr = 1'b0, last_ferr_p = 1'b0, last_perr_p = 1'b0;

  always @(negedge clk) begin
    if (rx_valid) begin
      valid_tot = valid_tot + 1;
      last_data = rx_data;
      last_ferr = frame_err;
      last_perr = parity_err;
    end
    if (overrun) ovr_tot = ovr_tot + 1;
    if (overrun && ovr_prev) ovr_dbl = ovr_dbl + 1;
    ovr_prev = overrun;
    if (busy) busy_tot = busy_tot + 1;
    if (rx_valid_p) begin
      valid_p_tot = valid_p_tot + 1;
      last_data_p = rx_data_p;
      last_ferr_p = frame_err_p;
      last_perr_p = parity_err_p;
    end
    if (overrun_p) ovr_p_tot = ovr_p_tot + 1;
    if (busy_p) busy_p_tot = busy_p_tot + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input bit sel_p, input logic v, input int n_clk);
    if (sel_p) rx_p = v;
    else rx = v;
    repeat (n_clk) @(negedge clk);
  endtask

  // Start bit plus data bits, LSB first.
  task automatic send_data(input bit sel_p, input logic [7:0] d);
    drive_bit(sel_p, 1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) drive_bit(sel_p, d[i], BIT_CLK);
  endtask

  // Full frame; the parity bit goes only to the parity-enabled receiver.
  task automatic send_frame(input bit sel_p, input logic [7:0] d, input logic pbit, input logic stop);
    send_data(sel_p, d);
    if (sel_p) drive_bit(sel_p, pbit, BIT_CLK);
    drive_bit(sel_p, stop, BIT_CLK);
    drive_bit(sel_p, 1'b1, 32);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         sel_p;
    logic       pbit;
    logic       stop;
    logic       exp_ferr;
    logic       exp_perr;
  } vec_t;

  vec_t       vecs [NV];
  int         v0, b0, o0, d0;
  logic [7:0] rd;
  logic       rs, rp, ep;

  initial begin
    vecs[0] = '{8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h0F, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{8'h0F, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{8'h81, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset state.
    repeat (4) @(negedge clk);
    check("reset_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_data", {24'd0, rx_data}, 32'd0);
    rst = 1'b0;
    repeat (64) @(negedge clk);

    // Table-driven frames.
    for (int i = 0; i < NV; i++) begin
      v0 = vecs[i].sel_p ? valid_p_tot : valid_tot;
      send_frame(vecs[i].sel_p, vecs[i].data, vecs[i].pbit, vecs[i].stop);
      if (vecs[i].sel_p) begin
        check($sformatf("vec%0d_data", i), {24'd0, last_data_p}, {24'd0, vecs[i].data});
        check($sformatf("vec%0d_ferr", i), {31'd0, last_ferr_p}, {31'd0, vecs[i].exp_ferr});
        check($sformatf("vec%0d_perr", i), {31'd0, last_perr_p}, {31'd0, vecs[i].exp_perr});
        check($sformatf("vec%0d_vcycles", i), valid_p_tot - v0, 32'd1);
      end else begin
        check($sformatf("vec%0d_data", i), {24'd0, last_data}, {24'd0, vecs[i].data});
        check($sformatf("vec%0d_ferr", i), {31'd0, last_ferr}, {31'd0, vecs[i].exp_ferr});
        check($sformatf("vec%0d_perr", i), {31'd0, last_perr}, {31'd0, vecs[i].exp_perr});
        check($sformatf("vec%0d_vcycles", i), valid_tot - v0, 32'd1);
      end
    end

    // Glitch on the start bit: 4 ticks low, then high again.
    v0 = valid_tot;
    b0 = busy_tot;
    drive_bit(1'b0, 1'b0, 64);
    drive_bit(1'b0, 1'b1, 36);
    check("glitch_busy_mid", {31'd0, busy}, 32'd1);
    drive_bit(1'b0, 1'b1, 80);
    check("glitch_busy_back", {31'd0, busy}, 32'd0);
    check("glitch_busy_seen", {31'd0, (busy_tot - b0) > 0}, 32'd1);
    drive_bit(1'b0, 1'b1, BIT_CLK);
    check("glitch_no_valid", valid_tot - v0, 32'd0);

    // Framing error with a held-low line (break); no retrigger until rx goes high.
    v0 = valid_tot;
    send_data(1'b0, 8'hA3);
    drive_bit(1'b0, 1'b0, 3 * BIT_CLK);
    check("ferr_data", {24'd0, last_data}, 32'hA3);
    check("ferr_flag", {31'd0, last_ferr}, 32'd1);
    check("ferr_one_frame", valid_tot - v0, 32'd1);
    check("ferr_busy_waithi", {31'd0, busy}, 32'd1);
    drive_bit(1'b0, 1'b1, 40);
    check("ferr_busy_released", {31'd0, busy}, 32'd0);
    drive_bit(1'b0, 1'b1, BIT_CLK);
    check("ferr_no_extra", valid_tot - v0, 32'd1);

    // Overrun: second frame dropped while the first is still held.
    rx_ready = 1'b0;
    send_frame(1'b0, 8'h12, 1'b0, 1'b1);
    check("ovr_first_valid", {31'd0, rx_valid}, 32'd1);
    o0 = ovr_tot;
    d0 = ovr_dbl;
    send_frame(1'b0, 8'h34, 1'b0, 1'b1);
    check("ovr_data_kept", {24'd0, rx_data}, 32'h12);
    check("ovr_pulse_count", ovr_tot - o0, 32'd1);
    check("ovr_pulse_width", ovr_dbl - d0, 32'd0);
    check("ovr_still_valid", {31'd0, rx_valid}, 32'd1);
    // Handshake with rx_clk frozen.
    rx_clk_en = 1'b0;
    repeat (32) @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    check("ovr_release_valid", {31'd0, rx_valid}, 32'd0);
    check("ovr_release_data", {24'd0, rx_data}, 32'h12);
    rx_clk_en = 1'b1;
    repeat (64) @(negedge clk);

    // Randomized frames against the reference rules.
    for (int i = 0; i < NR; i++) begin
      rd = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 3) != 0);
      v0 = valid_tot;
      send_frame(1'b0, rd, 1'b0, rs);
      check($sformatf("rnd%0d_data", i), {24'd0, last_data}, {24'd0, rd});
      check($sformatf("rnd%0d_ferr", i), {31'd0, last_ferr}, {31'd0, ~rs});
      check($sformatf("rnd%0d_vcycles", i), valid_tot - v0, 32'd1);
      rd = 8'($urandom_range(0, 255));
      rp = 1'($urandom_range(0, 1));
      ep = (($countones(rd) + int'(rp)) % 2) != 0;
      v0 = valid_p_tot;
      send_frame(1'b1, rd, rp, 1'b1);
      check($sformatf("rndp%0d_data", i), {24'd0, last_data_p}, {24'd0, rd});
      check($sformatf("rndp%0d_perr", i), {31'd0, last_perr_p}, {31'd0, ep});
      check($sformatf("rndp%0d_vcycles", i), valid_p_tot - v0, 32'd1);
    end

    // Reset mid-frame: hold a byte, then reset during bit 3 of the next frame.
    rx_ready = 1'b0;
    send_frame(1'b0, 8'h5A, 1'b0, 1'b1);
    check("rst_pre_valid", {31'd0, rx_valid}, 32'd1);
    drive_bit(1'b0, 1'b0, BIT_CLK);
    drive_bit(1'b0, 1'b0, BIT_CLK);
    drive_bit(1'b0, 1'b1, BIT_CLK);
    drive_bit(1'b0, 1'b1, BIT_CLK);
    drive_bit(1'b0, 1'b0, BIT_CLK / 2);
    rst = 1'b1;
    #1;
    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_data", {24'd0, rx_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_flags", {29'd0, frame_err, parity_err, overrun}, 32'd0);
    check("rst_p_data", {24'd0, rx_data_p}, 32'd0);
    rx = 1'b1;
    rx_ready = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    v0 = valid_tot;
    drive_bit(1'b0, 1'b1, 2 * BIT_CLK);
    check("rst_no_partial", valid_tot - v0, 32'd0);
    send_frame(1'b0, 8'hC3, 1'b0, 1'b1);
    check("post_rst_data", {24'd0, last_data}, 32'hC3);
    check("post_rst_flags", {30'd0, last_ferr, last_perr}, 32'd0);
    check("post_rst_vcycles", valid_tot - v0, 32'd1);
    check("parity_dut_no_overrun", ovr_p_tot, 32'd0);
    check("parity_dut_idle", {30'd0, busy_p, frame_err_p}, 32'd0);
    check("parity_dut_busy_seen", {31'd0, busy_p_tot > 0}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
